sap2_control_sequencer: RTL and testbench
=========================================

// Module: sap2_control_sequencer
// PURPOSE
//  Parametrised hardwired control sequencer for the SAP-class CPU. Replaces the fixed 6-state, 4-opcode sequencer.
//  Drives the control word each clock. Adds: store, load-immediate, jump, conditional jumps, a sticky halt,
//  run/stall and variable-length instructions (early return to fetch). Sits between IR/flags and the datapath.
// PARAMETERS
//  T_STATES  6  ring length, one-hot; legal >=6. States T1..T_STATES; Tk = t_state[k-1].
//  OPCODE_W  4  op_code width; opcode values are defined in sap_ctrl_defs.vh. Upper bits are 0-extended.
//  EARLY_END 1  1: an instruction returns to T1 after its last active state; 0: every instruction runs all T_STATES.
// PORTS
//  clk            in   1         system clock, rising edge
//  LOW_CLR        in   1         async active-low reset
//  op_code        in   OPCODE_W  IR opcode field; valid from T4 onward
//  zero_flag      in   1         accumulator==0
//  neg_flag       in   1         accumulator MSB
//  run            in   1         1: advance one T-state per clock; 0: stall
//  t_state        out  T_STATES  one-hot current T-state
//  PE             out  1         PC onto bus
//  inc            out  1         PC increment
//  PC_LD          out  1         PC load from bus (jump)
//  LOW_MAR_LD     out  1         MAR load, active low
//  LOW_ROM_OE     out  1         memory onto bus, active low
//  RAM_WE         out  1         memory write from bus
//  LOW_IR_LD / LOW_IR_OUT  out  1 each  IR load / IR operand onto bus, active low
//  LOW_ACC_LD     out  1         ACC load, active low
//  ACC_OE         out  1         ACC onto bus
//  LOW_B_LD       out  1         B load, active low
//  sub_add        out  1         ALU op: 1=sub, 0=add
//  subadd_out_en  out  1         ALU result onto bus
//  LOW_LD_OUT     out  1         output register load, active low
//  LOW_HALT       out  1         0 while halted
// BEHAVIOUR
//  Reset (async, LOW_CLR=0): t_state=T1, halt latch clear. All strobes are inactive: active-high=0, LOW_*=1.
//  adv = run & ~halt. State updates only on clocks where adv=1. Every strobe = decode(state,op,flags) & adv.
//  Stalled or halted cycles therefore drive no strobes, so inc and RAM_WE never repeat.
//  Fetch (all opcodes): T1 PE,MAR_LD | T2 inc | T3 ROM_OE,IR_LD.
//  Execute; "end" marks the last state, after which the ring goes to T1 when EARLY_END=1:
//   LDA  T4 IR_OUT,MAR_LD | T5 ROM_OE,ACC_LD end
//   ADD  T4 IR_OUT,MAR_LD | T5 ROM_OE,B_LD | T6 subadd_out_en,ACC_LD end
//   SUB  as ADD, and sub_add=1 in T6 only
//   STA  T4 IR_OUT,MAR_LD | T5 ACC_OE,RAM_WE end
//   LDI  T4 IR_OUT,ACC_LD end
//   JMP  T4 IR_OUT,PC_LD end
//   JZ   T4 IR_OUT, plus PC_LD if zero_flag end. JN is the same, using neg_flag. Flags are sampled in T4 only.
//   OUT  T4 ACC_OE,LOW_LD_OUT=0 end
//   HLT  T4 sets halt latch end. From then: state frozen at T4, LOW_HALT=0, no strobes, until reset.
//   other opcodes  NOP, T4 end
//  EARLY_END=0: states after "end" up to T_STATES drive nothing; the ring wraps T_STATES->T1.
//  T_STATES>6: extra states are always idle.
//  Reset mid-instruction aborts it immediately; the next fetch starts at T1.
//  Exactly one t_state bit is set at all times.
// CONFIGURATION
//  SAP2_SINGLE_STEP_EN defined:
//   - adds input step (1 bit).
//   - A rising edge is detected with one internal register (reset 0), giving a 1-cycle step_pulse.
//   - adv = (run | step_pulse) & ~halt, so run=0 executes exactly one T-state per step edge.
//  Undefined: no step port, adv as above.
// STRUCTURE
//  sap_ctrl_defs.vh: opcode localparams (LDA=0,ADD=1,SUB=2,STA=3,LDI=4,JMP=5,JZ=6,JN=7,OUT=14,HLT=15).
//  It also holds T-state index localparams.
//  Sub-module tstate_ring_counter holds the one-hot ring (T_STATES, adv, restart-to-T1, async LOW_CLR).
//  Decode logic and the halt latch stay in this module.
// TESTING
//  1 Reset with run=1: after LOW_CLR rises, t_state=000001; T1 PE=1,LOW_MAR_LD=0; T2 inc=1; T3 LOW_IR_LD=0.
//  2 ADD, EARLY_END=1: T6 LOW_ACC_LD=0, subadd_out_en=1, sub_add=0; next clk t_state=T1. SUB: sub_add=1 in T6.
//  3 LDA: T5 LOW_ROM_OE=0,LOW_ACC_LD=0, then T1. EARLY_END=0: T6 has all strobes inactive, then T1.
//  4 JZ: zero_flag=1 gives PC_LD=1 in T4; zero_flag=0 gives PC_LD=0; both return to T1 next clk.
//  5 HLT: LOW_HALT=0 from the clk after T4; t_state stays T4 for 20 clks, all strobes off; LOW_CLR pulse gives T1.
//  6 run=0 at T2 for 5 clks: t_state holds T2, inc=0 throughout; run=1 gives one inc pulse.
//    SINGLE_STEP_EN: 3 step edges give exactly 3 advances.

Source files
------------

// File: rtl/sap2_control_sequencer_pkg.sv
// sap2_control_sequencer_pkg: opcodes, T-state indices and the active-high control word
package sap2_control_sequencer_pkg;
    localparam int OP_LDA = 0;
    localparam int OP_ADD = 1;
    localparam int OP_SUB = 2;
    localparam int OP_STA = 3;
    localparam int OP_LDI = 4;
    localparam int OP_JMP = 5;
    localparam int OP_JZ  = 6;
    localparam int OP_JN  = 7;
    localparam int OP_OUT = 14;
    localparam int OP_HLT = 15;
    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;
    typedef struct packed {
        logic pe;
        logic inc;
        logic pc_ld;
        logic mar_ld;
        logic rom_oe;
        logic ram_we;
        logic ir_ld;
        logic ir_out;
        logic acc_ld;
        logic acc_oe;
        logic b_ld;
        logic sub_add;
        logic alu_oe;
        logic ld_out;
    } ctrl_t;
endpackage

// File: rtl/tstate_ring_counter.sv
// tstate_ring_counter: one-hot T-state ring with advance enable and restart-to-T1
module tstate_ring_counter #(
    parameter int T_STATES = 6
) (
    input  logic                clk,
    input  logic                LOW_CLR,
    input  logic                adv,
    input  logic                restart,
    output logic [T_STATES-1:0] t_state
);
    always_ff @(posedge clk or negedge LOW_CLR)
        if (!LOW_CLR) t_state <= T_STATES'(1);
        else if (adv) t_state <= restart ? T_STATES'(1) : {t_state[T_STATES-2:0], t_state[T_STATES-1]};
endmodule

// File: rtl/sap2_control_sequencer.sv
// sap2_control_sequencer: hardwired SAP control sequencer with halt latch and run/stall.
// Optional SAP2_SINGLE_STEP_EN adds a step input that advances one T-state per rising edge.
module sap2_control_sequencer
    import sap2_control_sequencer_pkg::*;
#(
    parameter int T_STATES  = 6,
    parameter int OPCODE_W  = 4,
    parameter int EARLY_END = 1
) (
    input  logic                clk,
    input  logic                LOW_CLR,
`ifdef SAP2_SINGLE_STEP_EN
    input  logic                step,
`endif
    input  logic [OPCODE_W-1:0] op_code,
    input  logic                zero_flag,
    input  logic                neg_flag,
    input  logic                run,
    output logic [T_STATES-1:0] t_state,
    output logic                PE,
    output logic                inc,
    output logic                PC_LD,
    output logic                LOW_MAR_LD,
    output logic                LOW_ROM_OE,
    output logic                RAM_WE,
    output logic                LOW_IR_LD,
    output logic                LOW_IR_OUT,
    output logic                LOW_ACC_LD,
    output logic                ACC_OE,
    output logic                LOW_B_LD,
    output logic                sub_add,
    output logic                subadd_out_en,
    output logic                LOW_LD_OUT,
    output logic                LOW_HALT
);
    logic [31:0] op;
    logic halt, adv, hlt_now, end_now, go;
    logic lda, add, sub, sta, ldi, jmp, jz, jn, out, hlt, mem;
    ctrl_t c, s;
    assign op  = 32'(op_code);
    assign lda = op == OP_LDA;
    assign add = op == OP_ADD;
    assign sub = op == OP_SUB;
    assign sta = op == OP_STA;
    assign ldi = op == OP_LDI;
    assign jmp = op == OP_JMP;
    assign jz  = op == OP_JZ;
    assign jn  = op == OP_JN;
    assign out = op == OP_OUT;
    assign hlt = op == OP_HLT;
    assign mem = lda | add | sub | sta;
`ifdef SAP2_SINGLE_STEP_EN
    logic step_q;
    always_ff @(posedge clk or negedge LOW_CLR)
        if (!LOW_CLR) step_q <= 1'b0;
        else step_q <= step;
    assign adv = (run | (step & ~step_q)) & ~halt & LOW_CLR;
`else
    assign adv = run & ~halt & LOW_CLR;
`endif
    always_comb begin
        c = '0;
        c.pe      = t_state[T1];
        c.inc     = t_state[T2];
        c.ir_ld   = t_state[T3];
        c.mar_ld  = t_state[T1] | (t_state[T4] & mem);
        c.rom_oe  = t_state[T3] | (t_state[T5] & (lda | add | sub));
        c.ir_out  = t_state[T4] & (mem | ldi | jmp | jz | jn);
        c.acc_ld  = (t_state[T4] & ldi) | (t_state[T5] & lda) | (t_state[T6] & (add | sub));
        c.b_ld    = t_state[T5] & (add | sub);
        c.alu_oe  = t_state[T6] & (add | sub);
        c.sub_add = t_state[T6] & sub;
        c.acc_oe  = (t_state[T4] & out) | (t_state[T5] & sta);
        c.ram_we  = t_state[T5] & sta;
        c.pc_ld   = t_state[T4] & (jmp | (jz & zero_flag) | (jn & neg_flag));
        c.ld_out  = t_state[T4] & out;
    end
    assign s       = adv ? c : '0;
    assign end_now = (t_state[T4] & ~(mem)) | (t_state[T5] & (lda | sta)) | (t_state[T6] & (add | sub));
    // HLT freezes the ring at T4 instead of restarting it
    assign hlt_now = adv & t_state[T4] & hlt;
    assign go      = adv & ~hlt_now;
    always_ff @(posedge clk or negedge LOW_CLR)
        if (!LOW_CLR) halt <= 1'b0;
        else if (hlt_now) halt <= 1'b1;
    tstate_ring_counter #(.T_STATES(T_STATES)) u_ring (
        .clk(clk), .LOW_CLR(LOW_CLR), .adv(go), .restart((EARLY_END != 0) && end_now), .t_state(t_state)
    );
    assign PE            = s.pe;
    assign inc           = s.inc;
    assign PC_LD         = s.pc_ld;
    assign LOW_MAR_LD    = ~s.mar_ld;
    assign LOW_ROM_OE    = ~s.rom_oe;
    assign RAM_WE        = s.ram_we;
    assign LOW_IR_LD     = ~s.ir_ld;
    assign LOW_IR_OUT    = ~s.ir_out;
    assign LOW_ACC_LD    = ~s.acc_ld;
    assign ACC_OE        = s.acc_oe;
    assign LOW_B_LD      = ~s.b_ld;
    assign sub_add       = s.sub_add;
    assign subadd_out_en = s.alu_oe;
    assign LOW_LD_OUT    = ~s.ld_out;
    assign LOW_HALT      = ~halt;
endmodule

// File: tb/tb_sap2_control_sequencer.sv
// tb_sap2_control_sequencer: random and directed checks of two sequencer builds against a micro-program model
module tb_sap2_control_sequencer;
    localparam logic [13:0] M_PE = 14'h2000, M_INC = 14'h1000, M_PCLD = 14'h0800, M_MAR = 14'h0400;
    localparam logic [13:0] M_ROM = 14'h0200, M_WE = 14'h0100, M_IRLD = 14'h0080, M_IROUT = 14'h0040;
    localparam logic [13:0] M_ACCLD = 14'h0020, M_ACCOE = 14'h0010, M_BLD = 14'h0008, M_SUB = 14'h0004;
    localparam logic [13:0] M_ALU = 14'h0002, M_OUT = 14'h0001;
    typedef logic [13:0] wq_t[$];
    logic clk = 0, LOW_CLR = 0, zero_flag = 0, neg_flag = 0, run = 0, step = 0;
    logic [3:0] op_code = 0;
    logic [5:0] t1;
    logic [6:0] t0;
    logic pe1, inc1, pcld1, mar1, rom1, we1, irld1, irout1, accld1, accoe1, bld1, sub1, alu1, out1, hn1;
    logic pe0, inc0, pcld0, mar0, rom0, we0, irld0, irout0, accld0, accoe0, bld0, sub0, alu0, out0, hn0;
    logic [13:0] got1, got0;
    int total = 0, bad = 0, k1, k0;
    bit h1, h0, step_q;
    always #5 clk = ~clk;
    assign got1 = {pe1, inc1, pcld1, ~mar1, ~rom1, we1, ~irld1, ~irout1, ~accld1, accoe1, ~bld1, sub1, alu1, ~out1};
    assign got0 = {pe0, inc0, pcld0, ~mar0, ~rom0, we0, ~irld0, ~irout0, ~accld0, accoe0, ~bld0, sub0, alu0, ~out0};
    sap2_control_sequencer dut (
        .clk(clk), .LOW_CLR(LOW_CLR),
`ifdef SAP2_SINGLE_STEP_EN
        .step(step),
`endif
        .op_code(op_code), .zero_flag(zero_flag), .neg_flag(neg_flag), .run(run), .t_state(t1),
        .PE(pe1), .inc(inc1), .PC_LD(pcld1), .LOW_MAR_LD(mar1), .LOW_ROM_OE(rom1), .RAM_WE(we1),
        .LOW_IR_LD(irld1), .LOW_IR_OUT(irout1), .LOW_ACC_LD(accld1), .ACC_OE(accoe1), .LOW_B_LD(bld1),
        .sub_add(sub1), .subadd_out_en(alu1), .LOW_LD_OUT(out1), .LOW_HALT(hn1));
    sap2_control_sequencer #(.T_STATES(7), .EARLY_END(0)) dut0 (
        .clk(clk), .LOW_CLR(LOW_CLR),
`ifdef SAP2_SINGLE_STEP_EN
        .step(step),
`endif
        .op_code(op_code), .zero_flag(zero_flag), .neg_flag(neg_flag), .run(run), .t_state(t0),
        .PE(pe0), .inc(inc0), .PC_LD(pcld0), .LOW_MAR_LD(mar0), .LOW_ROM_OE(rom0), .RAM_WE(we0),
        .LOW_IR_LD(irld0), .LOW_IR_OUT(irout0), .LOW_ACC_LD(accld0), .ACC_OE(accoe0), .LOW_B_LD(bld0),
        .sub_add(sub0), .subadd_out_en(alu0), .LOW_LD_OUT(out0), .LOW_HALT(hn0));

    // execute micro-program (T4 onward) of each instruction; its length fixes the early-end point
    function automatic wq_t prog(int op, bit zf, bit nf);
        case (op)
            0:  return '{M_IROUT | M_MAR, M_ROM | M_ACCLD};
            1:  return '{M_IROUT | M_MAR, M_ROM | M_BLD, M_ALU | M_ACCLD};
            2:  return '{M_IROUT | M_MAR, M_ROM | M_BLD, M_ALU | M_ACCLD | M_SUB};
            3:  return '{M_IROUT | M_MAR, M_ACCOE | M_WE};
            4:  return '{M_IROUT | M_ACCLD};
            5:  return '{M_IROUT | M_PCLD};
            6:  return '{M_IROUT | (zf ? M_PCLD : 14'h0)};
            7:  return '{M_IROUT | (nf ? M_PCLD : 14'h0)};
            14: return '{M_ACCOE | M_OUT};
            default: return '{14'h0};
        endcase
    endfunction
    function automatic logic [13:0] ref_word(int k, int op, bit zf, bit nf);
        wq_t p;
        if (k == 1) return M_PE | M_MAR;
        if (k == 2) return M_INC;
        if (k == 3) return M_ROM | M_IRLD;
        p = prog(op, zf, nf);
        return (k - 4 < int'(p.size())) ? p[k-4] : 14'h0;
    endfunction
    function automatic int next_k(int k, int n, bit early, int op);
        if (op == 15 && k == 4) return 4;
        if (early && k == 3 + int'(prog(op, 0, 0).size())) return 1;
        return k == n ? 1 : k + 1;
    endfunction
    function automatic bit adv_of(bit h);
        bit p = 0;
`ifdef SAP2_SINGLE_STEP_EN
        p = step & ~step_q;
`endif
        return (run | p) & ~h & LOW_CLR;
    endfunction
    task automatic model_reset();
        k1 = 1; k0 = 1; h1 = 0; h0 = 0; step_q = 0;
    endtask
    task automatic tick();
        bit a1, a0;
        int n1, n0;
        bit nh1, nh0;
        a1 = adv_of(h1); a0 = adv_of(h0);
        n1 = a1 ? next_k(k1, 6, 1, op_code) : k1;
        n0 = a0 ? next_k(k0, 7, 0, op_code) : k0;
        nh1 = h1 | (a1 && k1 == 4 && op_code == 15);
        nh0 = h0 | (a0 && k0 == 4 && op_code == 15);
        @(posedge clk); #1;
        k1 = n1; k0 = n0; h1 = nh1; h0 = nh0; step_q = step;
    endtask
    task automatic do_reset();
        LOW_CLR = 0; #1;
        model_reset();
        LOW_CLR = 1; #1;
    endtask
    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        run = 1; op_code = 1;
        @(posedge clk); #1;
        LOW_CLR = 0; #1;
        total++; if (t1 !== 6'b000001) begin bad++; $display("FAIL reset_t got=%b want=000001", t1); end
        total++; if (got1 !== 14'h0 || hn1 !== 1'b1) begin bad++; $display("FAIL reset_strobes got=%h halt_n=%b want=0000/1", got1, hn1); end
        model_reset(); LOW_CLR = 1; #1;
        total++; if (t1 !== 6'b000001 || got1 !== (M_PE | M_MAR)) begin bad++; $display("FAIL fetch_t1 t=%b got=%h want=%h", t1, got1, M_PE | M_MAR); end
        tick();
        total++; if (got1 !== M_INC) begin bad++; $display("FAIL fetch_t2 got=%h want=%h", got1, M_INC); end
        tick();
        total++; if (got1 !== (M_ROM | M_IRLD)) begin bad++; $display("FAIL fetch_t3 got=%h want=%h", got1, M_ROM | M_IRLD); end
    endtask

    task automatic test_add_sub();
        for (int s = 0; s < 2; s++) begin
            do_reset(); run = 1; op_code = 4'(1 + s);
            ticks(5);
            total++; if (t1 !== 6'b100000 || got1 !== (M_ALU | M_ACCLD | (s ? M_SUB : 14'h0)))
                begin bad++; $display("FAIL addsub_t6 op=%0d t=%b got=%h", op_code, t1, got1); end
            tick();
            total++; if (t1 !== 6'b000001) begin bad++; $display("FAIL addsub_return got=%b want=000001", t1); end
        end
    endtask

    task automatic test_lda();
        do_reset(); run = 1; op_code = 0;
        ticks(4);
        total++; if (got1 !== (M_ROM | M_ACCLD) || got0 !== (M_ROM | M_ACCLD))
            begin bad++; $display("FAIL lda_t5 got=%h got0=%h want=%h", got1, got0, M_ROM | M_ACCLD); end
        tick();
        total++; if (t1 !== 6'b000001) begin bad++; $display("FAIL lda_return got=%b want=000001", t1); end
        total++; if (t0 !== 7'b0100000 || got0 !== 14'h0) begin bad++; $display("FAIL lda_noearly_t6 t=%b got=%h", t0, got0); end
        tick();
        total++; if (t0 !== 7'b1000000 || got0 !== 14'h0) begin bad++; $display("FAIL lda_noearly_t7 t=%b got=%h", t0, got0); end
        tick();
        total++; if (t0 !== 7'b0000001) begin bad++; $display("FAIL lda_noearly_wrap got=%b want=0000001", t0); end
    endtask

    task automatic test_jz();
        for (int z = 0; z < 2; z++) begin
            do_reset(); run = 1; op_code = 6; zero_flag = z[0];
            ticks(3);
            total++; if (got1 !== (M_IROUT | (z ? M_PCLD : 14'h0))) begin bad++; $display("FAIL jz_t4 zf=%0d got=%h", z, got1); end
            tick();
            total++; if (t1 !== 6'b000001) begin bad++; $display("FAIL jz_return got=%b want=000001", t1); end
        end
    endtask

    task automatic test_hlt();
        do_reset(); run = 1; op_code = 15;
        ticks(3);
        total++; if (hn1 !== 1'b1 || got1 !== 14'h0) begin bad++; $display("FAIL hlt_t4 halt_n=%b got=%h", hn1, got1); end
        tick();
        for (int i = 0; i < 20; i++) begin
            op_code = 4'($urandom); run = 1'($urandom); #1;
            total++; if (hn1 !== 1'b0 || t1 !== 6'b001000 || got1 !== 14'h0)
                begin bad++; $display("FAIL hlt_frozen i=%0d halt_n=%b t=%b got=%h", i, hn1, t1, got1); end
            tick();
        end
        run = 1; do_reset();
        total++; if (t1 !== 6'b000001 || hn1 !== 1'b1) begin bad++; $display("FAIL hlt_clear t=%b halt_n=%b", t1, hn1); end
    endtask

    task automatic test_stall();
        do_reset(); run = 1; op_code = 4;
        tick();
        run = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (t1 !== 6'b000010 || inc1 !== 1'b0) begin bad++; $display("FAIL stall i=%0d t=%b inc=%b", i, t1, inc1); end
            tick();
        end
        run = 1; #1;
        total++; if (inc1 !== 1'b1) begin bad++; $display("FAIL stall_resume inc=%b want=1", inc1); end
        tick();
        total++; if (t1 !== 6'b000100 || inc1 !== 1'b0) begin bad++; $display("FAIL stall_once t=%b inc=%b", t1, inc1); end
    endtask

`ifdef SAP2_SINGLE_STEP_EN
    task automatic test_step();
        run = 0; step = 0; op_code = 1; do_reset(); tick();
        for (int i = 1; i <= 3; i++) begin
            step = 1; tick();
            step = 0; tick();
            total++; if (t1 !== 6'(1 << i)) begin bad++; $display("FAIL step i=%0d got=%b want=%b", i, t1, 6'(1 << i)); end
        end
    endtask
`endif

    task automatic test_random();
        logic [13:0] e1, e0;
        run = 1; do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin LOW_CLR = 0; #1; LOW_CLR = 1; model_reset(); end
            op_code = 4'($urandom_range(0, 14));
            zero_flag = 1'($urandom); neg_flag = 1'($urandom);
            run = ($urandom_range(0, 4) != 0);
`ifdef SAP2_SINGLE_STEP_EN
            step = 1'($urandom);
`endif
            #1;
            e1 = adv_of(h1) ? ref_word(k1, op_code, zero_flag, neg_flag) : 14'h0;
            e0 = adv_of(h0) ? ref_word(k0, op_code, zero_flag, neg_flag) : 14'h0;
            total++; if (t1 !== 6'(1 << (k1 - 1))) begin bad++; $display("FAIL rnd_t i=%0d got=%b want=T%0d", i, t1, k1); end
            total++; if (got1 !== e1) begin bad++; $display("FAIL rnd_ctrl i=%0d op=%0d got=%h want=%h", i, op_code, got1, e1); end
            total++; if (t0 !== 7'(1 << (k0 - 1))) begin bad++; $display("FAIL rnd_t0 i=%0d got=%b want=T%0d", i, t0, k0); end
            total++; if (got0 !== e0) begin bad++; $display("FAIL rnd_ctrl0 i=%0d op=%0d got=%h want=%h", i, op_code, got0, e0); end
            total++; if (hn1 !== ~h1) begin bad++; $display("FAIL rnd_halt i=%0d got=%b want=%b", i, hn1, ~h1); end
            tick();
        end
        step = 0;
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_lda();
        test_jz();
        test_hlt();
        test_stall();
`ifdef SAP2_SINGLE_STEP_EN
        test_step();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
